branch_update_unit: RTL and testbench

BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

---
 rtl/branch_update_unit.sv | 126 ++++++++++++
 tb/tb_branch_update_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_unit.sv
// Branch predictor update unit: 2-bit saturating counters with a coalescing write FIFO
// feeding the 1-bit prediction table. Optional statistics counters under BRANCH_STATS_EN.
module branch_update_unit #(
   parameter int unsigned INDEX_BITS = 6,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  branchE,
   input  logic [31:0]           pcE,
   input  logic                  predE,
   input  logic                  takenE,
   input  logic                  tbl_ready,
   output logic                  tbl_we,
   output logic [INDEX_BITS-1:0] tbl_addr,
   output logic                  tbl_wd,
   output logic                  mispredictE,
`ifdef BRANCH_STATS_EN
   output logic [31:0]           br_count,
   output logic [31:0]           mispred_count,
`endif
   output logic                  stall_req
);

   localparam int unsigned Entries = 2 ** INDEX_BITS;
   localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
   localparam int unsigned OccW    = PtrW + 1;
   localparam logic [OccW-1:0] FullOcc = OccW'(FIFO_DEPTH);

   logic [1:0]            ctrQ [Entries];
   logic [INDEX_BITS-1:0] addrQ [FIFO_DEPTH];
   logic                  wdQ [FIFO_DEPTH];
   logic [PtrW-1:0]       headQ, tailQ;
   logic [OccW-1:0]       occQ;

   logic [INDEX_BITS-1:0] idx;
   logic [1:0]            oldCnt, newCnt;
   logic                  flip, full, deq, accept, enq, coalesce;
   logic                  hitAny;
   logic [PtrW-1:0]       hitSlot, slotOff;
   logic                  unusedPc;

   assign idx      = pcE[INDEX_BITS+1:2];
   assign unusedPc = ^{pcE[31:INDEX_BITS+2], pcE[1:0]};
   assign oldCnt   = ctrQ[idx];

   always_comb begin
      newCnt = oldCnt;
      if (takenE) begin
         if (oldCnt != 2'b11) newCnt = oldCnt + 2'd1;
      end else begin
         if (oldCnt != 2'b00) newCnt = oldCnt - 2'd1;
      end
   end

   assign flip        = newCnt[1] ^ oldCnt[1];
   assign full        = (occQ == FullOcc);
   assign tbl_we      = (occQ != '0);
   assign deq         = tbl_we & tbl_ready;
   assign accept      = branchE & (~full | deq);
   assign mispredictE = branchE & (predE != takenE);
   assign stall_req   = full;
   assign tbl_addr    = tbl_we ? addrQ[headQ] : '0;
   assign tbl_wd      = tbl_we & wdQ[headQ];

   // Find a live entry with the same index; the head being dequeued this cycle is excluded.
   always_comb begin
      hitAny  = 1'b0;
      hitSlot = '0;
      slotOff = '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
         slotOff = PtrW'(j) - headQ;
         if (!hitAny && ({1'b0, slotOff} < occQ) && !(deq && slotOff == '0) &&
             addrQ[j] == idx) begin
            hitAny  = 1'b1;
            hitSlot = PtrW'(j);
         end
      end
   end

   assign enq      = accept & flip & ~hitAny;
   assign coalesce = accept & flip & hitAny;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < Entries; i++) ctrQ[i] <= 2'b01;
      end else if (accept) begin
         ctrQ[idx] <= newCnt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         headQ <= '0;
         tailQ <= '0;
         occQ  <= '0;
      end else begin
         if (deq) headQ <= headQ + 1'b1;
         if (enq) tailQ <= tailQ + 1'b1;
         if (enq && !deq)      occQ <= occQ + 1'b1;
         else if (deq && !enq) occQ <= occQ - 1'b1;
      end
   end

   // Payload needs no reset: outputs are gated by occupancy.
   always_ff @(posedge clk) begin
      if (enq) begin
         addrQ[tailQ] <= idx;
         wdQ[tailQ]   <= newCnt[1];
      end
      if (coalesce) wdQ[hitSlot] <= newCnt[1];
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else if (accept) begin
         br_count <= br_count + 32'd1;
         if (mispredictE) mispred_count <= mispred_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
// Randomized scoreboard bench for branch_update_unit against a queue-based reference model.
module tb_branch_update_unit;

   localparam int IB    = 6;
   localparam int DEPTH = 4;

   typedef struct packed {
      logic [IB-1:0] idx;
      logic          wd;
   } wr_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          branchE, predE, takenE, tbl_ready;
   logic [31:0]   pcE;
   logic          tbl_we, tbl_wd, mispredictE, stall_req;
   logic [IB-1:0] tbl_addr;
`ifdef BRANCH_STATS_EN
   logic [31:0]   br_count, mispred_count;
`endif

   int   checks = 0;
   int   errors = 0;
   wr_t  expQ[$];
   int   modelCtr [2**IB];
   logic [31:0] modelBr, modelMis;

   branch_update_unit #(.INDEX_BITS(IB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .branchE(branchE), .pcE(pcE), .predE(predE),
      .takenE(takenE), .tbl_ready(tbl_ready), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
      .tbl_wd(tbl_wd), .mispredictE(mispredictE),
`ifdef BRANCH_STATS_EN
      .br_count(br_count), .mispred_count(mispred_count),
`endif
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic modelClear();
      expQ.delete();
      for (int i = 0; i < 2**IB; i++) modelCtr[i] = 1;
      modelBr  = '0;
      modelMis = '0;
   endtask

   // Monitor: compares every cycle against the model, pops on each table write.
   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         chk("tbl_we", {31'd0, tbl_we}, {31'd0, expQ.size() != 0});
         chk("stall_req", {31'd0, stall_req}, {31'd0, expQ.size() == DEPTH});
`ifdef BRANCH_STATS_EN
         chk("br_count", br_count, modelBr);
         chk("mispred_count", mispred_count, modelMis);
`endif
         if (tbl_we === 1'b1 && tbl_ready === 1'b1 && expQ.size() != 0) begin
            e = expQ.pop_front();
            chk("tbl_addr", {26'd0, tbl_addr}, {26'd0, e.idx});
            chk("tbl_wd", {31'd0, tbl_wd}, {31'd0, e.wd});
         end
      end
   end

   task automatic step(input logic b, input logic [31:0] pc, input logic p, input logic t,
                       input logic r);
      int   sz, ix, oldc, newc;
      bit   deq, full, found;
      @(posedge clk);
      #2;
      branchE = b; pcE = pc; predE = p; takenE = t; tbl_ready = r;
      sz   = expQ.size();
      deq  = r && (sz != 0);
      full = (sz == DEPTH);
      #1;
      chk("mispredictE", {31'd0, mispredictE}, {31'd0, b && (p != t)});
      @(negedge clk);
      #1;
      if (b && (!full || deq)) begin
         ix   = int'((pc >> 2) & ((1 << IB) - 1));
         oldc = modelCtr[ix];
         newc = t ? (oldc == 3 ? 3 : oldc + 1) : (oldc == 0 ? 0 : oldc - 1);
         modelCtr[ix] = newc;
         modelBr++;
         if (p != t) modelMis++;
         if ((oldc >= 2) != (newc >= 2)) begin
            found = 0;
            foreach (expQ[k]) begin
               if (expQ[k].idx == IB'(ix)) begin
                  expQ[k].wd = (newc >= 2);
                  found = 1;
               end
            end
            if (!found) expQ.push_back('{idx: IB'(ix), wd: (newc >= 2)});
         end
      end
   endtask

   task automatic idle(input int n, input logic r);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0, r);
   endtask

   task automatic doReset(input int n);
      @(posedge clk);
      #2;
      reset   = 1'b1;
      branchE = 1'b0;
      modelClear();
      #1;
      chk("rst_tbl_we", {31'd0, tbl_we}, 32'd0);
      chk("rst_tbl_addr", {26'd0, tbl_addr}, 32'd0);
      chk("rst_tbl_wd", {31'd0, tbl_wd}, 32'd0);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      repeat (n) @(posedge clk);
      #2;
      reset = 1'b0;
   endtask

   function automatic logic [31:0] pcOf(input int ix);
      return ($urandom() & ~32'h0000_00FC) | (32'(ix) << 2);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int ix;
      reset = 1'b1; branchE = 0; pcE = 0; predE = 0; takenE = 0; tbl_ready = 0;
      modelClear();
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;

      // Single flip at idx 4, written the following cycle.
      step(1'b1, 32'h0000_0010, 1'b0, 1'b1, 1'b1);
      idle(3, 1'b1);

      // Not-taken saturation at idx 4: no writes.
      doReset(1);
      for (int i = 0; i < 4; i++) step(1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Fill, ignored resolve at idx 6, ordered drain, then prove counter 6 still 01.
      doReset(1);
      step(1'b1, pcOf(1), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(2), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(3), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(5), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(6), 1'b0, 1'b1, 1'b0);
      idle(6, 1'b1);
      step(1'b1, pcOf(6), 1'b0, 1'b1, 1'b1);
      idle(2, 1'b1);

      // Coalescing at idx 7.
      doReset(1);
      step(1'b1, pcOf(7), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(7), 1'b1, 1'b0, 1'b0);
      step(1'b1, pcOf(7), 1'b0, 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(3, 1'b1);

      // Mispredict and statistics.
      doReset(1);
      step(1'b1, pcOf(9), 1'b1, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Reset mid-drain discards pending writes.
      doReset(1);
      step(1'b1, pcOf(1), 1'b0, 1'b1, 1'b0);
      step(1'b1, pcOf(2), 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      doReset(2);
      idle(4, 1'b1);
      step(1'b1, pcOf(2), 1'b0, 1'b1, 1'b1);
      step(1'b1, pcOf(1), 1'b0, 1'b0, 1'b1);
      idle(2, 1'b1);

      // Randomized traffic over a small index set to provoke coalescing and full FIFO.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 199) == 0) doReset($urandom_range(1, 2));
         ix = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                          : int'($urandom_range(0, 5));
         step($urandom_range(0, 3) != 0, pcOf(ix), 1'($urandom()), 1'($urandom()),
              $urandom_range(0, 2) == 0);
      end

      idle(DEPTH + 4, 1'b1);
      chk("drain_empty", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
